realtank_soc_bus_arb_param: RTL

//  Output-stage arbiter for the RealTank SoC AHB bus matrix, one instance per slave port.

---
 rtl/realtank_soc_bus_arb_param.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/realtank_soc_bus_arb_param.sv
// Output-stage arbiter for one slave port of the RealTank AHB bus matrix.
// Picks the input port owning the address phase; fixed or round-robin priority, bursts never split.
module realtank_soc_bus_arb_param #(
    parameter int unsigned  NUM_PORTS = 4,
    parameter int unsigned  ARB_MODE  = 0,
    localparam int unsigned PORT_W    = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
    input  logic                 HCLK,
    input  logic                 HRESETn,
    input  logic [NUM_PORTS-1:0] req_port,
    input  logic                 HREADYM,
    input  logic                 HSELM,
    input  logic [1:0]           HTRANSM,
    input  logic [2:0]           HBURSTM,
    input  logic                 HMASTLOCKM,
    output logic [PORT_W-1:0]    addr_in_port,
    output logic [NUM_PORTS-1:0] grant,
    output logic                 no_port
);

    localparam logic [1:0] TrIdle   = 2'b00;
    localparam logic [1:0] TrBusy   = 2'b01;
    localparam logic [1:0] TrNonseq = 2'b10;
    localparam logic [1:0] TrSeq    = 2'b11;

    logic [3:0]           cnt_q, cnt_d;
    logic                 hold_q, hold_d;
    logic [PORT_W-1:0]    owner_q, owner_d;
    logic [PORT_W-1:0]    rr_q, rr_d;
    logic                 no_port_q, no_port_d;
    logic [NUM_PORTS-1:0] grant_q, grant_d;
    logic [NUM_PORTS-1:0] cand;
    logic [PORT_W-1:0]    winner;
    logic                 found;
    int unsigned          start;
    int unsigned          idx;

    // Burst tracker: hold stays set until the last SEQ beat of a fixed-length burst.
    always_comb begin
        cnt_d  = cnt_q;
        hold_d = hold_q;
        if (HREADYM) begin
            if (!HSELM) begin
                cnt_d  = 4'd0;
                hold_d = 1'b0;
            end else begin
                case (HTRANSM)
                    TrIdle: begin
                        cnt_d  = 4'd0;
                        hold_d = 1'b0;
                    end
                    TrBusy: ;
                    TrNonseq: begin
                        case (HBURSTM)
                            3'b111, 3'b110: begin cnt_d = 4'd15; hold_d = 1'b1; end
                            3'b101, 3'b100: begin cnt_d = 4'd7;  hold_d = 1'b1; end
                            3'b011, 3'b010: begin cnt_d = 4'd3;  hold_d = 1'b1; end
                            default:        begin cnt_d = 4'd0;  hold_d = 1'b0; end
                        endcase
                    end
                    TrSeq: begin
                        cnt_d = cnt_q - 4'd1;
                        if (cnt_q == 4'd1) begin
                            hold_d = 1'b0;
                        end
                    end
                    default: begin
                        cnt_d  = 4'd0;
                        hold_d = 1'b0;
                    end
                endcase
            end
        end
    end

    // The current owner stays a candidate while its transfer is still active.
    always_comb begin
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            cand[i] = req_port[i] | ((owner_q == PORT_W'(i)) && HSELM && (HTRANSM != TrIdle));
        end
    end

    always_comb begin
        start  = (ARB_MODE == 1) ? 32'(rr_q) : 0;
        winner = '0;
        found  = 1'b0;
        idx    = 0;
        for (int unsigned k = 0; k < NUM_PORTS; k++) begin
            idx = start + k;
            if (idx >= NUM_PORTS) begin
                idx = idx - NUM_PORTS;
            end
            if (!found && cand[PORT_W'(idx)]) begin
                found  = 1'b1;
                winner = PORT_W'(idx);
            end
        end
    end

    always_comb begin
        owner_d   = owner_q;
        no_port_d = no_port_q;
        rr_d      = rr_q;
        if (HREADYM) begin
            if (HMASTLOCKM || hold_d) begin
                owner_d = owner_q;
            end else if (found) begin
                owner_d   = winner;
                no_port_d = 1'b0;
                if ((ARB_MODE == 1) && ((winner != owner_q) || no_port_q)) begin
                    rr_d = (winner == PORT_W'(NUM_PORTS - 1)) ? '0 : winner + 1'b1;
                end
            end else if (HSELM) begin
                no_port_d = 1'b0;
            end else begin
                no_port_d = 1'b1;
            end
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            grant_d[i] = !no_port_d && (owner_d == PORT_W'(i));
        end
    end

    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            cnt_q     <= 4'd0;
            hold_q    <= 1'b0;
            owner_q   <= '0;
            rr_q      <= '0;
            no_port_q <= 1'b1;
            grant_q   <= '0;
        end else begin
            cnt_q     <= cnt_d;
            hold_q    <= hold_d;
            owner_q   <= owner_d;
            rr_q      <= rr_d;
            no_port_q <= no_port_d;
            grant_q   <= grant_d;
        end
    end

    assign addr_in_port = owner_q;
    assign grant        = grant_q;
    assign no_port      = no_port_q;

endmodule
